// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and FSM state encodings shared by the LSU memory slave.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
endpackage

// File: rtl/lsu_axi_sram_slave_if.sv
// lsu_axi_sram_slave_if: single-beat AXI-lite style read/write channels between LSU and memory.
interface lsu_axi_sram_slave_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic              w_valid;
    logic              w_ready;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/sram_word_array.sv
// sram_word_array: byte-enabled synchronous-write word array with combinational read.
module sram_word_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IW-1:0]       w_idx,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [IW-1:0]       r_idx,
    output logic [DATA_W-1:0]   r_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < DATA_W/8; i++)
                if (w_strb[i]) mem_q[w_idx][i*8 +: 8] <= w_data[i*8 +: 8];
    end

    // A write landing on the word being read this cycle is forwarded so reads see the new bytes.
    always_comb begin
        r_data = mem_q[r_idx];
        if (we && w_idx == r_idx)
            for (int i = 0; i < DATA_W/8; i++)
                if (w_strb[i]) r_data[i*8 +: 8] = w_data[i*8 +: 8];
    end
endmodule

// File: rtl/lsu_axi_sram_slave.sv
// lsu_axi_sram_slave: single-outstanding AXI-lite memory slave with programmable read latency
// and SLVERR on addresses outside the backing window.
module lsu_axi_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int                READ_LAT  = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    lsu_axi_sram_slave_if.slave s_axi
);
    localparam int SB = DATA_W/8;
    localparam int SH = $clog2(SB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(READ_LAT) + 1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a >= BASE_ADDR && ((a - BASE_ADDR) >> SH) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IW'((a - BASE_ADDR) >> SH);
    endfunction

    wr_state_t         wr_state_q, wr_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [SB-1:0]     w_strb_q, w_strb_d;
    logic [1:0]        b_resp_q, b_resp_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d;
    logic              aw_rdy, w_rdy, we, sample;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd, mem_rdata;
    logic [SB-1:0]     ws;

    assign aw_rdy = wr_state_q == W_IDLE && !aw_held_q;
    assign w_rdy  = wr_state_q == W_IDLE && !w_held_q;
    assign wa     = aw_held_q ? aw_addr_q : s_axi.aw_addr;
    assign wd     = w_held_q ? w_data_q : s_axi.w_data;
    assign ws     = w_held_q ? w_strb_q : s_axi.w_strb;
    // In R_IDLE the live AR address is used so READ_LAT=1 can sample on the handshake edge.
    assign ra     = rd_state_q == R_IDLE ? s_axi.ar_addr : ar_addr_q;

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_resp_d   = b_resp_q;
        we         = 1'b0;
        if (s_axi.aw_valid && aw_rdy) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axi.aw_addr;
        end
        if (s_axi.w_valid && w_rdy) begin
            w_held_d = 1'b1;
            w_data_d = s_axi.w_data;
            w_strb_d = s_axi.w_strb;
        end
        if (wr_state_q == W_IDLE && aw_held_d && w_held_d) begin
            we         = in_range(wa);
            b_resp_d   = in_range(wa) ? RESP_OKAY : RESP_SLVERR;
            wr_state_d = W_RESP;
            aw_held_d  = 1'b0;
            w_held_d   = 1'b0;
        end
        if (wr_state_q == W_RESP && s_axi.b_ready) wr_state_d = W_IDLE;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_addr_d  = ar_addr_q;
        cnt_d      = cnt_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        sample     = 1'b0;
        if (rd_state_q == R_IDLE && s_axi.ar_valid) begin
            ar_addr_d  = s_axi.ar_addr;
            cnt_d      = CW'(READ_LAT - 1);
            sample     = READ_LAT == 1;
            rd_state_d = READ_LAT == 1 ? R_RESP : R_WAIT;
        end
        if (rd_state_q == R_WAIT) begin
            cnt_d  = cnt_q - 1'b1;
            sample = cnt_q <= CW'(1);
        end
        if (sample) begin
            r_data_d   = in_range(ra) ? mem_rdata : '0;
            r_resp_d   = in_range(ra) ? RESP_OKAY : RESP_SLVERR;
            rd_state_d = R_RESP;
        end
        if (rd_state_q == R_RESP && s_axi.r_ready) rd_state_d = R_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_resp_q   <= RESP_OKAY;
            rd_state_q <= R_IDLE;
            ar_addr_q  <= '0;
            cnt_q      <= '0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_resp_q   <= b_resp_d;
            rd_state_q <= rd_state_d;
            ar_addr_q  <= ar_addr_d;
            cnt_q      <= cnt_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    sram_word_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk    (clk),
        .we     (we),
        .w_idx  (word_idx(wa)),
        .w_data (wd),
        .w_strb (ws),
        .r_idx  (word_idx(ra)),
        .r_data (mem_rdata)
    );

    assign s_axi.aw_ready = aw_rdy;
    assign s_axi.w_ready  = w_rdy;
    assign s_axi.b_valid  = wr_state_q == W_RESP;
    assign s_axi.b_resp   = b_resp_q;
    assign s_axi.ar_ready = rd_state_q == R_IDLE;
    assign s_axi.r_valid  = rd_state_q == R_RESP;
    assign s_axi.r_data   = r_data_q;
    assign s_axi.r_resp   = r_resp_q;
endmodule

// File: tb/tb_lsu_axi_sram_slave.sv
// tb_lsu_axi_sram_slave: table-driven write/read vectors plus directed sequences for
// reset, delayed W, back-pressure and same-edge write/read hazards.
module tb_lsu_axi_sram_slave;
    localparam int READ_LAT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    lsu_axi_sram_slave_if bus ();

    lsu_axi_sram_slave #(.READ_LAT(READ_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (bus.slave)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  b_resp;
        logic [63:0] r_data;
        logic [1:0]  r_resp;
    } vec_t;

    vec_t v[9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp);
        bus.aw_valid = 1'b1;
        bus.aw_addr  = a;
        bus.w_valid  = 1'b1;
        bus.w_data   = d;
        bus.w_strb   = s;
        bus.b_ready  = 1'b0;
        tick();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        chk("wr_latency_b_valid", 64'(bus.b_valid), 64'd1);
        resp = bus.b_resp;
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        chk("wr_done_aw_ready", 64'(bus.aw_ready), 64'd1);
    endtask

    task automatic do_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
        int n;
        chk("rd_ar_ready", 64'(bus.ar_ready), 64'd1);
        bus.ar_valid = 1'b1;
        bus.ar_addr  = a;
        bus.r_ready  = 1'b0;
        tick();
        bus.ar_valid = 1'b0;
        n = 1;
        while (!bus.r_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rd_latency", 64'(n), 64'(READ_LAT));
        d    = bus.r_data;
        resp = bus.r_resp;
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [63:0] rd;
        v[0] = '{64'h8000_0010, 64'h1122334455667788, 8'hFF, 2'b00, 64'h1122334455667788, 2'b00};
        v[1] = '{64'h8000_0010, 64'h00000000000000AB, 8'h01, 2'b00, 64'h11223344556677AB, 2'b00};
        v[2] = '{64'h8000_0000, 64'h5555555555555555, 8'hFF, 2'b00, 64'h5555555555555555, 2'b00};
        v[3] = '{64'h8000_0018, 64'hCAFEBABEDEADBEEF, 8'hFF, 2'b00, 64'hCAFEBABEDEADBEEF, 2'b00};
        v[4] = '{64'h8000_001C, 64'h0000000011112222, 8'h0C, 2'b00, 64'hCAFEBABE1111BEEF, 2'b00};
        v[5] = '{64'h8000_8000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b10, 64'h0,                2'b10};
        v[6] = '{64'h0000_1000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2'b10, 64'h0,                2'b10};
        v[7] = '{64'h8000_7FF8, 64'h0123456789ABCDEF, 8'hFF, 2'b00, 64'h0123456789ABCDEF, 2'b00};
        v[8] = '{64'h8000_0000, 64'h0,                8'h00, 2'b00, 64'h5555555555555555, 2'b00};

        bus.aw_valid = 1'b0; bus.aw_addr = '0;
        bus.w_valid  = 1'b0; bus.w_data  = '0; bus.w_strb = '0;
        bus.b_ready  = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_addr = '0;
        bus.r_ready  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("rst_w_ready",  64'(bus.w_ready),  64'd1);
        chk("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
        chk("rst_b_valid",  64'(bus.b_valid),  64'd0);
        chk("rst_r_valid",  64'(bus.r_valid),  64'd0);
        chk("rst_r_data",   bus.r_data,        64'd0);
        chk("rst_resps",    64'({bus.b_resp, bus.r_resp}), 64'd0);

        // reset asserted while a read waits on its latency
        bus.ar_valid = 1'b1;
        bus.ar_addr  = 64'h8000_0010;
        tick();
        bus.ar_valid = 1'b0;
        chk("rd_busy_ar_ready", 64'(bus.ar_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_r_valid",  64'(bus.r_valid),  64'd0);
        chk("midrst_ar_ready", 64'(bus.ar_ready), 64'd1);
        chk("midrst_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("midrst_w_ready",  64'(bus.w_ready),  64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_r_valid", 64'(bus.r_valid), 64'd0);

        for (int i = 0; i < 9; i++) begin
            do_write(v[i].addr, v[i].data, v[i].strb, br);
            chk($sformatf("vec%0d_b_resp", i), 64'(br), 64'(v[i].b_resp));
            do_read(v[i].addr, rd, rr);
            chk($sformatf("vec%0d_r_data", i), rd, v[i].r_data);
            chk($sformatf("vec%0d_r_resp", i), 64'(rr), 64'(v[i].r_resp));
        end

        // AW in cycle 0, W in cycle 3, B held off for 4 cycles
        bus.aw_valid = 1'b1;
        bus.aw_addr  = 64'h8000_0020;
        chk("dly_c0_aw_ready", 64'(bus.aw_ready), 64'd1);
        tick();
        bus.aw_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            chk($sformatf("dly_c%0d_aw_ready", c), 64'(bus.aw_ready), 64'd0);
            chk($sformatf("dly_c%0d_w_ready", c),  64'(bus.w_ready),  64'd1);
            chk($sformatf("dly_c%0d_b_valid", c),  64'(bus.b_valid),  64'd0);
            tick();
        end
        bus.w_valid = 1'b1;
        bus.w_data  = 64'h7766554433221100;
        bus.w_strb  = 8'hFF;
        chk("dly_c3_aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("dly_c3_w_ready",  64'(bus.w_ready),  64'd1);
        tick();
        bus.w_valid = 1'b0;
        chk("dly_c4_w_ready", 64'(bus.w_ready), 64'd0);
        for (int c = 4; c < 8; c++) begin
            chk($sformatf("dly_c%0d_b_valid", c), 64'(bus.b_valid), 64'd1);
            chk($sformatf("dly_c%0d_b_resp", c),  64'(bus.b_resp),  64'd0);
            tick();
        end
        bus.b_ready = 1'b1;
        chk("dly_c8_b_valid", 64'(bus.b_valid), 64'd1);
        tick();
        bus.b_ready = 1'b0;
        chk("dly_rel_b_valid",  64'(bus.b_valid),  64'd0);
        chk("dly_rel_aw_ready", 64'(bus.aw_ready), 64'd1);
        chk("dly_rel_w_ready",  64'(bus.w_ready),  64'd1);
        do_read(64'h8000_0020, rd, rr);
        chk("dly_readback", rd, 64'h7766554433221100);

        // write commits on the same edge the read samples the same word
        do_write(64'h8000_0030, 64'h0, 8'hFF, br);
        bus.ar_valid = 1'b1;
        bus.ar_addr  = 64'h8000_0030;
        tick();
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b1;
        bus.aw_addr  = 64'h8000_0030;
        bus.w_valid  = 1'b1;
        bus.w_data   = 64'd5;
        bus.w_strb   = 8'hFF;
        tick();
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        chk("haz_r_valid", 64'(bus.r_valid), 64'd1);
        chk("haz_r_data",  bus.r_data,       64'd5);
        chk("haz_b_valid", 64'(bus.b_valid), 64'd1);
        bus.b_ready  = 1'b1;
        bus.ar_valid = 1'b1;
        bus.ar_addr  = 64'h8000_0010;
        chk("haz_ar_blocked", 64'(bus.ar_ready), 64'd0);
        tick();
        bus.b_ready = 1'b0;
        chk("haz_ar_blocked2", 64'(bus.ar_ready), 64'd0);
        chk("haz_r_stable",    bus.r_data,        64'd5);
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        chk("haz_ar_reopen", 64'(bus.ar_ready), 64'd1);
        tick();
        bus.ar_valid = 1'b0;
        begin
            int n;
            n = 1;
            while (!bus.r_valid && n < 20) begin
                tick();
                n++;
            end
            chk("held_ar_latency", 64'(n), 64'(READ_LAT));
        end
        chk("held_ar_r_data", bus.r_data, 64'h11223344556677AB);
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
